// File: rtl/lms_pkg.sv
// lms_pkg: shared FSM states, Q-format constants and saturation helper for the LMS/FIR path
package lms_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ERR = 2'd1, UPD = 2'd2, SHIFT = 2'd3} state_t;
  localparam int Q_FRAC = 15;
  function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return x > hi ? hi : x < lo ? lo : x;
  endfunction
endpackage

// File: rtl/lms_tap_mac.sv
// lms_tap_mac: single-tap multiply, shift, saturate and accumulate; leaky when LMS_LEAK_EN is defined
module lms_tap_mac
  import lms_pkg::*;
#(
  parameter int DW = 16,
  parameter int MU_SHIFT = 4,
  parameter int LEAK_SHIFT = 10
) (
  input  logic signed [DW-1:0] e_q,
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] w,
  input  logic                 en,
  output logic signed [DW-1:0] w_next
);
  logic signed [2*DW-1:0] prod;
  logic signed [63:0] delta, sum;
  assign prod = e_q * x;
  assign delta = sat(64'(prod >>> (Q_FRAC + MU_SHIFT)), DW);
`ifdef LMS_LEAK_EN
  assign sum = 64'(w) - 64'(w >>> LEAK_SHIFT) + delta;
`else
  assign sum = 64'(w) + delta;
`endif
  assign w_next = en ? DW'(sat(sum, DW)) : w;
endmodule

// File: rtl/lms_coeff_update.sv
// lms_coeff_update: sequential LMS weight update, one tap per cycle; leaky variant via LMS_LEAK_EN
module lms_coeff_update
  import lms_pkg::*;
#(
  parameter int NTAPS = 101,
  parameter int DW = 16,
  parameter int ACCW = 32,
  parameter int MU_SHIFT = 4,
  parameter int LEAK_SHIFT = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [DW-1:0]   sample_in,
  input  logic signed [ACCW-1:0] filtered_sample,
  input  logic signed [DW-1:0]   desired,
  input  logic                   adapt_en,
  input  logic                   coef_clear,
  output logic signed [DW-1:0]   coefficients [0:NTAPS-1],
  output logic signed [DW-1:0]   x_hist [0:NTAPS-1],
  output logic signed [DW-1:0]   err_out,
  output logic                   update_done,
  output logic                   busy
);
  localparam int IW = $clog2(NTAPS);
  state_t st;
  logic [IW-1:0] idx;
  logic signed [DW-1:0] x_l, d_l, e_q, w_next;
  logic signed [ACCW-1:0] f_l;
  logic signed [ACCW+1:0] e;
  logic a_l;
  assign in_ready = st == IDLE && !coef_clear;
  assign busy = st != IDLE;
  assign e = ((ACCW+2)'(d_l) <<< Q_FRAC) - (ACCW+2)'(f_l);
  assign e_q = DW'(sat(64'(e >>> Q_FRAC), DW));
  lms_tap_mac #(.DW(DW), .MU_SHIFT(MU_SHIFT), .LEAK_SHIFT(LEAK_SHIFT)) u_mac (
    .e_q(err_out),
    .x(x_hist[idx]),
    .w(coefficients[idx]),
    .en(a_l),
    .w_next(w_next)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      idx <= '0;
      x_l <= '0;
      d_l <= '0;
      f_l <= '0;
      a_l <= 1'b0;
      err_out <= '0;
      update_done <= 1'b0;
    end else begin
      update_done <= st == SHIFT;
      case (st)
        IDLE: if (in_valid && in_ready) begin
          x_l <= sample_in;
          d_l <= desired;
          f_l <= filtered_sample;
          a_l <= adapt_en;
          st <= ERR;
        end
        ERR: begin
          err_out <= e_q;
          idx <= '0;
          st <= UPD;
        end
        UPD: begin
          idx <= idx + 1'b1;
          if (idx == IW'(NTAPS - 1)) st <= SHIFT;
        end
        default: st <= IDLE;
      endcase
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < NTAPS; k++) begin
        coefficients[k] <= '0;
        x_hist[k] <= '0;
      end
    end else begin
      if (st == IDLE && coef_clear)
        for (int k = 0; k < NTAPS; k++) coefficients[k] <= '0;
      if (st == UPD) coefficients[idx] <= w_next;
      if (st == SHIFT) begin
        x_hist[0] <= x_l;
        for (int k = 1; k < NTAPS; k++) x_hist[k] <= x_hist[k-1];
      end
    end
endmodule

// File: tb/tb_lms_coeff_update.sv
// tb_lms_coeff_update: randomized self-checking bench against an arithmetic LMS reference model
module tb_lms_coeff_update;
  localparam int N = 101;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, adapt_en = 1'b0, coef_clear = 1'b0;
  logic in_ready, update_done, busy;
  logic signed [15:0] sample_in = '0, desired = '0, err_out;
  logic signed [31:0] filtered_sample = '0;
  logic signed [15:0] coefficients [0:N-1];
  logic signed [15:0] x_hist [0:N-1];
  int n_chk = 0, n_fail = 0;
  longint mw [N];
  longint mx [N];
  longint me;
  always #5 clk = ~clk;
  lms_coeff_update dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sample_in(sample_in), .filtered_sample(filtered_sample), .desired(desired),
    .adapt_en(adapt_en), .coef_clear(coef_clear), .coefficients(coefficients),
    .x_hist(x_hist), .err_out(err_out), .update_done(update_done), .busy(busy)
  );
  function automatic longint sat(input longint v);
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mw[i] = 0;
      mx[i] = 0;
    end
    me = 0;
  endtask
  task automatic model_tx(input int s, input int f, input int d, input bit a);
    longint dl, lk;
    me = sat(((longint'(d) * 32768) - longint'(f)) >>> 15);
    if (a)
      for (int i = 0; i < N; i++) begin
        dl = sat((me * mx[i]) >>> 19);
`ifdef LMS_LEAK_EN
        lk = mw[i] >>> 10;
`else
        lk = 0;
`endif
        mw[i] = sat(mw[i] - lk + dl);
      end
    for (int i = N - 1; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = s;
  endtask
  task automatic finish_tx(input string name);
    int n, bad;
    n = 1;
    n_chk++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_cycle1: busy=%b in_ready=%b want 1 0", name, busy, in_ready);
    end
    while (update_done !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_chk++;
    if (n !== 104) begin
      n_fail++;
      $display("FAIL %s latency: done at cycle %0d want 104", name, n);
    end
    n_chk++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s idle_at_done: busy=%b in_ready=%b want 0 1", name, busy, in_ready);
    end
    n_chk++;
    if (err_out !== 16'(me)) begin
      n_fail++;
      $display("FAIL %s err_out: got %0d want %0d", name, err_out, me);
    end
    bad = -1;
    for (int i = 0; i < N; i++) if (bad < 0 && coefficients[i] !== 16'(mw[i])) bad = i;
    n_chk++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s coef[%0d]: got %0d want %0d", name, bad, coefficients[bad], mw[bad]);
    end
    bad = -1;
    for (int i = 0; i < N; i++) if (bad < 0 && x_hist[i] !== 16'(mx[i])) bad = i;
    n_chk++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s x_hist[%0d]: got %0d want %0d", name, bad, x_hist[bad], mx[bad]);
    end
  endtask
  task automatic send(input string name, input int s, input int f, input int d, input bit a);
    @(negedge clk);
    sample_in = 16'(s);
    filtered_sample = f;
    desired = 16'(d);
    adapt_en = a;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_tx(s, f, d, a);
    finish_tx(name);
  endtask
  task automatic test_reset();
    int bad;
    bad = 0;
    for (int i = 0; i < N; i++) if (coefficients[i] !== 16'sd0 || x_hist[i] !== 16'sd0) bad++;
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_arrays: %0d nonzero entries want 0", bad);
    end
    n_chk++;
    if (in_ready !== 1'b1 || update_done !== 1'b0 || busy !== 1'b0 || err_out !== 16'sd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: in_ready=%b done=%b busy=%b err=%0d want 1 0 0 0",
               in_ready, update_done, busy, err_out);
    end
  endtask
  task automatic test_basic();
    send("basic1", 16384, 0, 0, 1'b1);
    send("basic2", 0, 0, 16384, 1'b1);
    n_chk++;
    if (err_out !== 16'sd16384 || coefficients[0] !== 16'sd512 || coefficients[1] !== 16'sd0 ||
        x_hist[1] !== 16'sd16384) begin
      n_fail++;
      $display("FAIL basic_const: err=%0d w0=%0d w1=%0d x1=%0d want 16384 512 0 16384",
               err_out, coefficients[0], coefficients[1], x_hist[1]);
    end
  endtask
  task automatic test_saturation();
    for (int t = 0; t < 20; t++) send("sat", 32767, -32'sd2147483648, 32767, 1'b1);
    n_chk++;
    if (err_out !== 16'sd32767 || coefficients[0] !== 16'sd32767) begin
      n_fail++;
      $display("FAIL sat_const: err=%0d w0=%0d want 32767 32767", err_out, coefficients[0]);
    end
  endtask
  task automatic test_freeze();
    logic signed [15:0] snap [0:N-1];
    int bad;
    for (int i = 0; i < N; i++) snap[i] = coefficients[i];
    send("freeze", int'($urandom_range(0, 65535)) - 32768, 12345678, -20000, 1'b0);
    bad = 0;
    for (int i = 0; i < N; i++) if (coefficients[i] !== snap[i]) bad++;
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL freeze_hold: %0d coefficients changed want 0", bad);
    end
  endtask
  task automatic test_back_to_back();
    int s, d, f;
    for (int t = 0; t < 8; t++) begin
      s = int'($urandom_range(0, 65535)) - 32768;
      d = int'($urandom_range(0, 65535)) - 32768;
      f = t[0] ? int'($urandom) : d * 32768 + int'($urandom_range(0, 2097152)) - 1048576;
      send("b2b", s, f, d, t != 5);
    end
  endtask
  task automatic test_reset_mid();
    int bad;
    @(negedge clk);
    sample_in = 16'sd1000;
    filtered_sample = 0;
    desired = 16'sd9000;
    adapt_en = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (51) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    bad = 0;
    for (int i = 0; i < N; i++) if (coefficients[i] !== 16'sd0 || x_hist[i] !== 16'sd0) bad++;
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL midreset_arrays: %0d nonzero entries want 0", bad);
    end
    n_chk++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || update_done !== 1'b0 || err_out !== 16'sd0) begin
      n_fail++;
      $display("FAIL midreset_ctrl: busy=%b in_ready=%b done=%b err=%0d want 0 1 0 0",
               busy, in_ready, update_done, err_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_release: busy=%b in_ready=%b want 0 1", busy, in_ready);
    end
  endtask
  task automatic test_clear();
    int bad;
    send("pre_clear1", 20000, -32'sd2147483648, 32767, 1'b1);
    send("pre_clear2", -15000, -32'sd2147483648, 32767, 1'b1);
    @(negedge clk);
    sample_in = 16'sd777;
    filtered_sample = 32'sd5000000;
    desired = -16'sd3000;
    adapt_en = 1'b1;
    in_valid = 1'b1;
    coef_clear = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_ready: in_ready=%b want 0", in_ready);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) mw[i] = 0;
    bad = 0;
    for (int i = 0; i < N; i++) if (coefficients[i] !== 16'sd0) bad++;
    n_chk++;
    if (bad != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_apply: %0d nonzero weights busy=%b want 0 0", bad, busy);
    end
    coef_clear = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_tx(777, 5000000, -3000, 1'b1);
    finish_tx("after_clear");
  endtask
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_saturation();
    test_freeze();
    test_back_to_back();
    test_reset_mid();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
